alu_rr_sequencer: RTL and testbench

Shares the single ALU between two requesters (e.g. the decode stage and the test/debug port). Round-robin arbitration, valid/ready request handshake, and issue of operands to the ALU. The block waits the ALU latency, captures the result and returns it on a valid/ready response channel tagged with the requester id. The ALU stays external and is driven through the alu_* ports.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/rr_arb2.sv | 19 +
 rtl/alu_rr_sequencer.sv | 156 +++++++++++++++
 tb/tb_alu_rr_sequencer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Op codes, FSM encoding and id width shared by the ALU sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam logic [3:0] ADD = 4'd0;
    localparam logic [3:0] SUB = 4'd1;
    localparam logic [3:0] AND = 4'd2;
    localparam logic [3:0] OR  = 4'd3;
    localparam logic [3:0] XOR = 4'd4;
    localparam logic [3:0] NOT = 4'd5;
    localparam logic [3:0] SLA = 4'd6;
    localparam logic [3:0] SRA = 4'd7;
    localparam logic [3:0] SRL = 4'd8;

    localparam logic [3:0] FUNCT_MAX = SRL;

    localparam int ID_W = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } seq_state_t;

    function automatic logic funct_legal(input logic [3:0] funct);
        return (funct <= FUNCT_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-way round-robin grant; the requester not granted last wins a tie.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    assign grant_valid = valid0 | valid1;
    assign grant_id    = (valid0 && valid1) ? ~last_grant : valid1;

endmodule
`default_nettype wire

// File: rtl/alu_rr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_sequencer
// Brief    : Shares one external ALU between two requesters, round-robin,
//            and returns each result on a tagged valid/ready channel.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_sequencer
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int CNT_W   = 2
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [3:0]  req0_a,
    input  logic [3:0]  req0_b,
    input  logic [1:0]  req0_shamt,
    input  logic [3:0]  req0_funct,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [3:0]  req1_a,
    input  logic [3:0]  req1_b,
    input  logic [1:0]  req1_shamt,
    input  logic [3:0]  req1_funct,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_data,
    output logic        rsp_err,

    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic [1:0]  alu_shamt,
    output logic [3:0]  alu_funct,
    input  logic [31:0] alu_out,

    output logic        busy
);

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last_grant;

    logic             w_grant_valid;
    logic             w_grant_id;
    logic             w_accept;
    logic             w_capture;
    logic             w_legal;

    logic [3:0]       w_sel_a;
    logic [3:0]       w_sel_b;
    logic [1:0]       w_sel_shamt;
    logic [3:0]       w_sel_funct;

    rr_arb2 u_arb (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    assign w_sel_a     = w_grant_id ? req1_a     : req0_a;
    assign w_sel_b     = w_grant_id ? req1_b     : req0_b;
    assign w_sel_shamt = w_grant_id ? req1_shamt : req0_shamt;
    assign w_sel_funct = w_grant_id ? req1_funct : req0_funct;
    assign w_legal     = funct_legal(w_sel_funct);

    assign rsp_valid = (r_state == RESP);
    assign busy      = (r_state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Ready is gated by rst_n so nothing is offered while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_capture   = 1'b0;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant_valid && rst_n) begin
                    w_accept    = 1'b1;
                    req0_ready  = ~w_grant_id;
                    req1_ready  = w_grant_id;
                    w_state_nxt = w_legal ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_last_grant <= 1'b1;
            rsp_id       <= 1'b0;
            rsp_data     <= '0;
            rsp_err      <= 1'b0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_shamt    <= '0;
            alu_funct    <= '0;
        end else begin
            if (w_accept) begin
                rsp_id       <= w_grant_id;
                r_last_grant <= w_grant_id;
                if (w_legal) begin
                    alu_a     <= w_sel_a;
                    alu_b     <= w_sel_b;
                    alu_shamt <= w_sel_shamt;
                    alu_funct <= w_sel_funct;
                    r_cnt     <= CNT_W'(ALU_LAT);
                end else begin
                    rsp_data <= '0;
                    rsp_err  <= 1'b1;
                end
            end else if ((r_state == WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_capture) begin
                rsp_data <= alu_out;
                rsp_err  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rr_sequencer
// Brief    : Self-checking bench: transaction-level model plus directed and
//            random stimulus for the shared-ALU sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rr_sequencer;

    localparam int ALU_LAT = 1;
    localparam int CNT_W   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_a, req0_b, req0_funct, req1_a, req1_b, req1_funct;
    logic [1:0]  req0_shamt, req1_shamt;
    logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0] rsp_data;
    logic [31:0] alu_out = '0;
    logic [3:0]  alu_a, alu_b, alu_funct;
    logic [1:0]  alu_shamt;
    logic        busy;

    alu_rr_sequencer #(.ALU_LAT(ALU_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_shamt(req0_shamt), .req0_funct(req0_funct),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_shamt(req1_shamt), .req1_funct(req1_funct),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_err(rsp_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_funct(alu_funct),
        .alu_out(alu_out), .busy(busy)
    );

    always #5 clk = ~clk;

    // Operands are zero-extended to 32 bits before the operation.
    function automatic logic [31:0] alu_fn(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] sh, input logic [3:0] f);
        logic [31:0] ea, eb;
        ea = {28'd0, a};
        eb = {28'd0, b};
        case (f)
            4'd0:    return ea + eb;
            4'd1:    return ea - eb;
            4'd2:    return ea & eb;
            4'd3:    return ea | eb;
            4'd4:    return ea ^ eb;
            4'd5:    return ~ea;
            4'd6:    return ea << sh;
            4'd7:    return $signed(ea) >>> sh;
            4'd8:    return ea >> sh;
            default: return 32'd0;
        endcase
    endfunction

    // External ALU stand-in with ALU_LAT = 1 register stage.
    always @(posedge clk) alu_out <= alu_fn(alu_a, alu_b, alu_shamt, alu_funct);

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Staged stimulus, applied at each falling edge.
    logic       s_rstn, s_v0, s_v1, s_rr, auto_drop;
    logic [3:0] s_a0, s_b0, s_f0, s_a1, s_b1, s_f1;
    logic [1:0] s_sh0, s_sh1;

    // Transaction-level model.
    typedef struct {
        logic        id;
        logic [31:0] data;
        logic        err;
        int          acc;
        int          rdy;
    } rsp_t;
    rsp_t        rlog[$];
    int          cyc_n = 0;
    logic        m_busy, m_last, m_id, m_err, m_rv_now;
    logic [31:0] m_data;
    int          m_acc, m_rdy_at;
    logic [3:0]  m_alu_a, m_alu_b, m_alu_f;
    logic [1:0]  m_alu_sh;

    function automatic logic pick(input logic v0, input logic v1, input logic last);
        return (v0 && v1) ? !last : v1;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_last = 1'b1; m_id = 1'b0; m_err = 1'b0; m_data = '0;
        m_alu_a = '0; m_alu_b = '0; m_alu_f = '0; m_alu_sh = '0; m_rv_now = 1'b0;
    endtask

    task automatic compare();
        logic gv, gid, e_r0, e_r1, e_rv;
        gv   = req0_valid || req1_valid;
        gid  = pick(req0_valid, req1_valid, m_last);
        e_r0 = rst_n && !m_busy && gv && !gid;
        e_r1 = rst_n && !m_busy && gv && gid;
        e_rv = rst_n && m_busy && (cyc_n >= m_rdy_at);
        m_rv_now = e_rv;
        chk("req0_ready", req0_ready, e_r0);
        chk("req1_ready", req1_ready, e_r1);
        chk("rsp_valid", rsp_valid, e_rv);
        chk("busy", busy, m_busy);
        chk("alu_a", alu_a, m_alu_a);
        chk("alu_b", alu_b, m_alu_b);
        chk("alu_shamt", alu_shamt, m_alu_sh);
        chk("alu_funct", alu_funct, m_alu_f);
        if (!rst_n) begin
            chk("rst_rsp_data", rsp_data, 32'd0);
            chk("rst_rsp_id", rsp_id, 1'b0);
            chk("rst_rsp_err", rsp_err, 1'b0);
        end else if (e_rv) begin
            chk("rsp_data", rsp_data, m_data);
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_err", rsp_err, m_err);
        end
    endtask

    task automatic advance();
        logic g;
        logic [3:0] a, b, f;
        logic [1:0] sh;
        if (rst_n) begin
            if (m_busy) begin
                if (cyc_n >= m_rdy_at && rsp_ready) begin
                    rlog.push_back('{m_id, m_data, m_err, m_acc, m_rdy_at});
                    m_busy = 1'b0;
                end
            end else if (req0_valid || req1_valid) begin
                g  = pick(req0_valid, req1_valid, m_last);
                a  = g ? req1_a : req0_a;
                b  = g ? req1_b : req0_b;
                sh = g ? req1_shamt : req0_shamt;
                f  = g ? req1_funct : req0_funct;
                m_busy = 1'b1; m_id = g; m_last = g; m_acc = cyc_n;
                if (auto_drop) begin
                    if (g) s_v1 = 1'b0; else s_v0 = 1'b0;
                end
                if (f <= 4'd8) begin
                    m_alu_a = a; m_alu_b = b; m_alu_sh = sh; m_alu_f = f;
                    m_data = alu_fn(a, b, sh, f); m_err = 1'b0;
                    m_rdy_at = cyc_n + ALU_LAT + 2;
                end else begin
                    m_data = '0; m_err = 1'b1;
                    m_rdy_at = cyc_n + 1;
                end
            end
        end
        cyc_n++;
    endtask

    task automatic cyc();
        @(negedge clk);
        rst_n = s_rstn;
        req0_valid = s_v0; req0_a = s_a0; req0_b = s_b0; req0_shamt = s_sh0; req0_funct = s_f0;
        req1_valid = s_v1; req1_a = s_a1; req1_b = s_b1; req1_shamt = s_sh1; req1_funct = s_f1;
        rsp_ready = s_rr;
        if (!rst_n) model_reset();
        #1;
        compare();
        advance();
    endtask

    task automatic run_until(input int n, input int budget);
        int k = 0;
        while (rlog.size() < n && k < budget) begin
            cyc();
            k++;
        end
    endtask

    task automatic expect_log(input int idx, input string nm, input logic id,
                              input logic [31:0] data, input logic err, input int lat);
        if (idx >= rlog.size()) begin
            checks++;
            errors++;
            $display("FAIL %s: response %0d never arrived, got %0d responses", nm, idx, rlog.size());
        end else begin
            chk({nm, "_id"}, rlog[idx].id, id);
            chk({nm, "_data"}, rlog[idx].data, data);
            chk({nm, "_err"}, rlog[idx].err, err);
            chk({nm, "_lat"}, rlog[idx].rdy - rlog[idx].acc, lat);
        end
    endtask

    initial begin
        int base, hold, quiet, k;
        s_rstn = 1'b0; s_v0 = 1'b0; s_v1 = 1'b0; s_rr = 1'b1; auto_drop = 1'b1;
        s_a0 = '0; s_b0 = '0; s_f0 = '0; s_sh0 = '0;
        s_a1 = '0; s_b1 = '0; s_f1 = '0; s_sh1 = '0;
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req0_shamt = '0; req0_funct = '0;
        req1_a = '0; req1_b = '0; req1_shamt = '0; req1_funct = '0;
        model_reset();
        repeat (3) cyc();
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        s_rstn = 1'b1;
        cyc();

        // Single ADD 12+3 from requester 0.
        s_v0 = 1'b1; s_a0 = 4'd12; s_b0 = 4'd3; s_sh0 = 2'd0; s_f0 = 4'd0;
        base = rlog.size();
        cyc();
        chk("add_req0_ready", req0_ready, 1'b1);
        chk("add_req1_ready", req1_ready, 1'b0);
        run_until(base + 1, 20);
        expect_log(base, "add", 1'b0, 32'd15, 1'b0, 3);

        // Tie straight after reset: requester 0 first.
        s_rstn = 1'b0; repeat (2) cyc(); s_rstn = 1'b1;
        s_v0 = 1'b1; s_a0 = 4'd12; s_b0 = 4'd3; s_f0 = 4'd1;
        s_v1 = 1'b1; s_a1 = 4'd12; s_b1 = 4'd3; s_sh1 = 2'd0; s_f1 = 4'd3;
        base = rlog.size();
        run_until(base + 2, 30);
        expect_log(base, "tie0", 1'b0, 32'd9, 1'b0, 3);
        expect_log(base + 1, "tie1", 1'b1, 32'd15, 1'b0, 3);

        // Fairness with both valids held.
        auto_drop = 1'b0;
        s_v0 = 1'b1; s_a0 = 4'd12; s_b0 = 4'd3; s_f0 = 4'd2;
        s_v1 = 1'b1; s_a1 = 4'd12; s_b1 = 4'd3; s_sh1 = 2'd2; s_f1 = 4'd7;
        base = rlog.size();
        run_until(base + 6, 60);
        for (int i = 0; i < 6; i++)
            expect_log(base + i, "fair", i[0], i[0] ? 32'd3 : 32'd0, 1'b0, 3);
        s_v0 = 1'b0; s_v1 = 1'b0; auto_drop = 1'b1;
        cyc();

        // Backpressure, then an illegal op from requester 1 that waited.
        s_rr = 1'b0;
        s_v0 = 1'b1; s_a0 = 4'd12; s_b0 = 4'd3; s_sh0 = 2'd0; s_f0 = 4'd4;
        base = rlog.size();
        k = 0;
        while (!m_rv_now && k < 20) begin cyc(); k++; end
        s_v1 = 1'b1; s_a1 = 4'd5; s_b1 = 4'd6; s_sh1 = 2'd1; s_f1 = 4'd12;
        hold = 0;
        repeat (5) begin cyc(); if (rsp_valid) hold++; end
        chk("bp_hold_cycles", hold, 5);
        chk("bp_data", rsp_data, 32'd15);
        chk("bp_id", rsp_id, 1'b0);
        s_rr = 1'b1;
        run_until(base + 2, 20);
        expect_log(base, "bp", 1'b0, 32'd15, 1'b0, 3);
        expect_log(base + 1, "illegal", 1'b1, 32'd0, 1'b1, 1);
        chk("illegal_keeps_funct", alu_funct, 4'd4);

        // Asynchronous reset while the op is waiting on the ALU.
        s_v0 = 1'b1; s_a0 = 4'd12; s_b0 = 4'd3; s_f0 = 4'd1;
        k = 0;
        while (!m_busy && k < 10) begin cyc(); k++; end
        cyc();
        #2;
        rst_n = 1'b0; req0_valid = 1'b1; s_rstn = 1'b0; s_v0 = 1'b0;
        model_reset();
        #1;
        chk("areset_busy", busy, 1'b0);
        chk("areset_rsp_valid", rsp_valid, 1'b0);
        chk("areset_req0_ready", req0_ready, 1'b0);
        chk("areset_alu_funct", alu_funct, 4'd0);
        chk("areset_alu_a", alu_a, 4'd0);
        repeat (2) cyc();
        s_rstn = 1'b1;
        quiet = 0;
        repeat (6) begin cyc(); if (rsp_valid) quiet++; end
        chk("no_rsp_after_reset", quiet, 0);
        s_v0 = 1'b1; s_a0 = 4'd12; s_b0 = 4'd3; s_f0 = 4'd4;
        base = rlog.size();
        run_until(base + 1, 20);
        expect_log(base, "post_reset", 1'b0, 32'd15, 1'b0, 3);

        // Random traffic.
        auto_drop = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            s_v0  = ($urandom_range(0, 2) != 0);
            s_v1  = ($urandom_range(0, 2) != 0);
            s_rr  = ($urandom_range(0, 9) < 7);
            s_a0  = 4'($urandom); s_b0 = 4'($urandom); s_sh0 = 2'($urandom);
            s_a1  = 4'($urandom); s_b1 = 4'($urandom); s_sh1 = 2'($urandom);
            s_f0  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            s_f1  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            cyc();
        end
        s_v0 = 1'b0; s_v1 = 1'b0; s_rr = 1'b1;
        repeat (10) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
